inv_mulcheck_seq: RTL

- Sequential modular multiplier that checks inversion results in the prime field.
- Computes prod = (a·b) mod p, one bit of b per cycle, using MSB-first interleaved shift-add.
- Flags whether b is the inverse of a, i.e. whether prod == 1.
- Built as the checking side of the inversion soft IP: a candidate from the inversion IP is fed back as b, and the result confirms a·b ≡ 1 (mod p) on-chip.

---
 rtl/inv_ip_pkg.sv | 14 +
 rtl/mod_dbl_add_step.sv | 28 ++
 rtl/inv_mulcheck_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/inv_ip_pkg.sv
// Shared types and constants for the inversion IP: FSM states, default width, index width.
package inv_ip_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int IP_WIDTH_DEF = 5;

  function automatic int idx_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int IP_IDX_W = idx_width(IP_WIDTH_DEF);

endpackage

// File: rtl/mod_dbl_add_step.sv
// One MSB-first interleaved step: res = ((2*acc mod p) + mul_bit*a) mod p.
// Purely combinational; relies on acc < p and a < p so one conditional subtract suffices.
module mod_dbl_add_step
  import inv_ip_pkg::*;
#(
  parameter int IP_WIDTH = IP_WIDTH_DEF
) (
  input  logic [IP_WIDTH-1:0] acc,
  input  logic [IP_WIDTH-1:0] a,
  input  logic [IP_WIDTH-1:0] p,
  input  logic                mul_bit,
  output logic [IP_WIDTH-1:0] res
);

  logic [IP_WIDTH:0]   p_ext;
  logic [IP_WIDTH:0]   t;
  logic [IP_WIDTH-1:0] t_red;
  logic [IP_WIDTH:0]   u;

  always_comb begin
    p_ext = {1'b0, p};
    t     = {acc, 1'b0};
    t_red = (t >= p_ext) ? IP_WIDTH'(t - p_ext) : t[IP_WIDTH-1:0];
    u     = {1'b0, t_red} + (mul_bit ? {1'b0, a} : '0);
    res   = (u >= p_ext) ? IP_WIDTH'(u - p_ext) : u[IP_WIDTH-1:0];
  end

endmodule

// File: rtl/inv_mulcheck_seq.sv
// Sequential (a*b) mod p checker, 1 bit of b per cycle (2 with INV_MULCHECK_RADIX4_EN); latency IP_WIDTH+1
// (ceil(IP_WIDTH/2)+1 in radix-4), 1 on range error; in_valid while busy is dropped, no backpressure.
module inv_mulcheck_seq
  import inv_ip_pkg::*;
#(
  parameter int IP_WIDTH = IP_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IP_WIDTH-1:0] in_a,
  input  logic [IP_WIDTH-1:0] in_b,
  input  logic [IP_WIDTH-1:0] in_p,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_prod,
  output logic                out_is_inv,
  output logic                out_err
);

  localparam int IW = idx_width(IP_WIDTH);
`ifdef INV_MULCHECK_RADIX4_EN
  // b is zero-extended to an even bit count so the pairs line up
  localparam int NB   = ((IP_WIDTH + 1) / 2) * 2;
  localparam int STEP = 2;
`else
  localparam int NB   = IP_WIDTH;
  localparam int STEP = 1;
`endif

  state_t              st;
  logic [IP_WIDTH-1:0] a_r;
  logic [IP_WIDTH-1:0] p_r;
  logic [IP_WIDTH-1:0] acc;
  logic [NB-1:0]       b_r;
  logic [IW-1:0]       idx;
  logic                err_r;
  logic [IP_WIDTH-1:0] acc_nxt;
  logic                range_bad;

  assign range_bad = (in_a >= in_p) || (in_b >= in_p) || (in_p < IP_WIDTH'(3));

`ifdef INV_MULCHECK_RADIX4_EN
  logic [IP_WIDTH-1:0] acc_mid;
  logic [IW-1:0]       idx_lo;

  assign idx_lo = idx - IW'(1);

  mod_dbl_add_step #(.IP_WIDTH(IP_WIDTH)) u_step_hi (
    .acc(acc), .a(a_r), .p(p_r), .mul_bit(b_r[idx]), .res(acc_mid)
  );
  mod_dbl_add_step #(.IP_WIDTH(IP_WIDTH)) u_step_lo (
    .acc(acc_mid), .a(a_r), .p(p_r), .mul_bit(b_r[idx_lo]), .res(acc_nxt)
  );
`else
  mod_dbl_add_step #(.IP_WIDTH(IP_WIDTH)) u_step (
    .acc(acc), .a(a_r), .p(p_r), .mul_bit(b_r[idx]), .res(acc_nxt)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      a_r        <= '0;
      p_r        <= '0;
      acc        <= '0;
      b_r        <= '0;
      idx        <= '0;
      err_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_prod   <= '0;
      out_is_inv <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_prod   <= '0;
      out_is_inv <= 1'b0;
      out_err    <= 1'b0;
      case (st)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= NB'(in_b);
            p_r   <= in_p;
            acc   <= '0;
            idx   <= IW'(NB - 1);
            err_r <= range_bad;
            st    <= range_bad ? DONE : CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (idx == IW'(STEP - 1)) st <= DONE;
          else idx <= idx - IW'(STEP);
        end
        DONE: begin
          out_valid  <= 1'b1;
          out_prod   <= acc;
          out_is_inv <= (acc == IP_WIDTH'(1)) && !err_r;
          out_err    <= err_r;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
